// File: rtl/fir_pkg.sv
// Shared types, rounding constant and saturation limits for the FIR rounding/decimation slice.
package fir_pkg;

    localparam int DEF_IN_W  = 26;
    localparam int DEF_OUT_W = 16;

    typedef logic signed [DEF_IN_W-1:0]  sample_in_t;
    typedef logic signed [DEF_IN_W:0]    sample_ext_t;
    typedef logic signed [DEF_OUT_W-1:0] sample_out_t;

    function automatic longint round_half(input int frac);
        return longint'(1) << (frac - 1);
    endfunction

    function automatic longint sat_max(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

    localparam longint OUT_MAX = sat_max(DEF_OUT_W);
    localparam longint OUT_MIN = sat_min(DEF_OUT_W);

endpackage

// File: rtl/fir_sync_fifo.sv
// First-word fall-through synchronous FIFO with full/empty/count; DEPTH must be a power of 2.
module fir_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    always_comb begin
        full    = (r_count == (AW+1)'(DEPTH));
        empty   = (r_count == '0);
        count   = r_count;
        w_pop   = rd_en && !empty;
        // A write into a full FIFO is accepted only when a pop frees the slot this cycle.
        w_push  = wr_en && (!full || w_pop);
        rd_data = empty ? '0 : r_mem[r_rptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= wr_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fir_round_decim.sv
// Round-half-up, decimate and buffer FIR output samples.
// Define FIR_ROUND_DECIM_SAT_EN to clip instead of wrapping on output-range overflow.
module fir_round_decim
    import fir_pkg::*;
#(
    parameter int INPUT_WIDTH  = 26,
    parameter int OUTPUT_WIDTH = 16,
    parameter int FRAC_BITS    = 8,
    parameter int DECIM        = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           valid_in,
    input  logic signed [INPUT_WIDTH-1:0]  din,
    input  logic                           phase_clr,
    output logic                           valid_out,
    input  logic                           ready_out,
    output logic signed [OUTPUT_WIDTH-1:0] dout,
    output logic                           sat,
    output logic                           overflow
);

    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PW-1:0]              LAST = PW'(DECIM - 1);
    localparam logic signed [INPUT_WIDTH:0] HALF = (INPUT_WIDTH+1)'(round_half(FRAC_BITS));

    logic [PW-1:0]                  r_phase;
    logic [PW-1:0]                  w_phase_cur;
    logic                           w_keep;
    logic signed [INPUT_WIDTH:0]    w_sum;
    logic signed [INPUT_WIDTH:0]    r_s1;
    logic                           r_s1_v;
    logic [OUTPUT_WIDTH-1:0]        w_s2;
    logic                           w_s2_sat;
    logic [OUTPUT_WIDTH-1:0]        r_s2;
    logic                           r_s2_v;
    logic                           r_s2_sat;
    logic                           w_full;
    logic                           w_empty;
    logic                           w_pop;
    logic [OUTPUT_WIDTH-1:0]        w_head;
    logic [$clog2(FIFO_DEPTH):0]    w_count;
    logic                           r_sat;
    logic                           r_overflow;

    always_comb begin
        w_phase_cur = phase_clr ? '0 : r_phase;
        w_keep      = valid_in && (w_phase_cur == '0);
        w_sum       = {din[INPUT_WIDTH-1], din} + HALF;
    end

`ifdef FIR_ROUND_DECIM_SAT_EN
    localparam logic signed [INPUT_WIDTH:0]    MAXV  = (INPUT_WIDTH+1)'(sat_max(OUTPUT_WIDTH));
    localparam logic signed [INPUT_WIDTH:0]    MINV  = (INPUT_WIDTH+1)'(sat_min(OUTPUT_WIDTH));
    localparam logic signed [OUTPUT_WIDTH-1:0] MAXO  = OUTPUT_WIDTH'(sat_max(OUTPUT_WIDTH));
    localparam logic signed [OUTPUT_WIDTH-1:0] MINO  = OUTPUT_WIDTH'(sat_min(OUTPUT_WIDTH));

    always_comb begin
        w_s2     = r_s1[OUTPUT_WIDTH-1:0];
        w_s2_sat = 1'b0;
        if (r_s1 > MAXV) begin
            w_s2     = MAXO;
            w_s2_sat = 1'b1;
        end else if (r_s1 < MINV) begin
            w_s2     = MINO;
            w_s2_sat = 1'b1;
        end
    end
`else
    always_comb begin
        w_s2     = r_s1[OUTPUT_WIDTH-1:0];
        w_s2_sat = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= '0;
            r_s1       <= '0;
            r_s1_v     <= 1'b0;
            r_s2       <= '0;
            r_s2_v     <= 1'b0;
            r_s2_sat   <= 1'b0;
            r_sat      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (valid_in) begin
                r_phase <= (w_phase_cur == LAST) ? '0 : w_phase_cur + 1'b1;
            end else begin
                r_phase <= w_phase_cur;
            end
            r_s1     <= w_sum >>> FRAC_BITS;
            r_s1_v   <= w_keep;
            r_s2     <= w_s2;
            r_s2_v   <= r_s1_v;
            r_s2_sat <= w_s2_sat;
            // sat flags only samples that actually land in the FIFO.
            r_sat    <= r_s2_v && r_s2_sat && (!w_full || w_pop);
            if (r_s2_v && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    fir_sync_fifo #(
        .WIDTH (OUTPUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (r_s2_v),
        .wr_data (r_s2),
        .rd_en   (ready_out),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    always_comb begin
        valid_out = !w_empty;
        w_pop     = ready_out && !w_empty;
        dout      = w_head;
        sat       = r_sat;
        overflow  = r_overflow;
    end

endmodule

// File: tb/tb_fir_round_decim.sv
// Directed, table-driven bench for fir_round_decim (default parameters).
module tb_fir_round_decim;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               valid_in = 1'b0;
    logic               phase_clr = 1'b0;
    logic               ready_out = 1'b0;
    logic signed [25:0] din = '0;
    logic               valid_out;
    logic               sat;
    logic               overflow;
    logic signed [15:0] dout;

    int total = 0;
    int bad = 0;
    logic signed [15:0] q[$];

    typedef struct {
        int din;
        int ew;
        bit sw;
        int es;
        bit ss;
    } vec_t;

    vec_t tbl[12];

    always #5 clk = ~clk;

    fir_round_decim #(
        .INPUT_WIDTH  (26),
        .OUTPUT_WIDTH (16),
        .FRAC_BITS    (8),
        .DECIM        (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .din       (din),
        .phase_clr (phase_clr),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .dout      (dout),
        .sat       (sat),
        .overflow  (overflow)
    );

    always @(negedge clk) begin
        if (rst_n && valid_out && ready_out) q.push_back(dout);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int v, input bit clr);
        valid_in  = 1'b1;
        din       = 26'(v);
        phase_clr = clr;
        tick();
        valid_in  = 1'b0;
        phase_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        q.delete();
    endtask

    task automatic check_q(input string nm, input int exp[$]);
        chk({nm, " count"}, q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < q.size()) chk($sformatf("%s[%0d]", nm, i), q[i], exp[i]);
        end
    endtask

    initial begin
        bit vo[12];
        tbl[0]  = '{384,       2,      0, 2,      0};
        tbl[1]  = '{-384,     -1,      0, -1,     0};
        tbl[2]  = '{383,       1,      0, 1,      0};
        tbl[3]  = '{128,       1,      0, 1,      0};
        tbl[4]  = '{-128,      0,      0, 0,      0};
        tbl[5]  = '{-129,     -1,      0, -1,     0};
        tbl[6]  = '{8388479,   32767,  0, 32767,  0};
        tbl[7]  = '{8388480,  -32768,  0, 32767,  1};
        tbl[8]  = '{-8388736, -32768,  0, -32768, 0};
        tbl[9]  = '{-8388737,  32767,  0, -32768, 1};
        tbl[10] = '{33554431,  0,      0, 32767,  1};
        tbl[11] = '{-33554432, 0,      0, -32768, 1};

        // reset state
        repeat (2) tick();
        @(negedge clk);
        chk("reset valid_out", valid_out, 0);
        chk("reset dout", dout, 0);
        chk("reset sat", sat, 0);
        chk("reset overflow", overflow, 0);
        rst_n = 1'b1;
        tick();

        // rounding / reduction table, each sample forced to phase 0
        ready_out = 1'b1;
        for (int i = 0; i < 12; i++) begin
            int ed;
            bit es;
`ifdef FIR_ROUND_DECIM_SAT_EN
            ed = tbl[i].es;
            es = tbl[i].ss;
`else
            ed = tbl[i].ew;
            es = tbl[i].sw;
`endif
            strobe(tbl[i].din, 1'b1);
            tick();
            tick();
            @(negedge clk);
            chk($sformatf("vec%0d valid", i), valid_out, 1);
            chk($sformatf("vec%0d dout din=%0d", i, tbl[i].din), dout, ed);
            chk($sformatf("vec%0d sat", i), sat, es);
            tick();
        end
        repeat (2) tick();
        chk("table drained", valid_out, 0);

        // back-to-back decimation with first-sample latency
        do_reset();
        ready_out = 1'b1;
        for (int i = 0; i < 12; i++) begin
            valid_in = 1'b1;
            din      = 26'(i * 256);
            tick();
            @(negedge clk);
            vo[i] = valid_out;
        end
        valid_in = 1'b0;
        chk("latency c1", vo[0], 0);
        chk("latency c2", vo[1], 0);
        chk("latency c3", vo[2], 1);
        repeat (6) tick();
        check_q("decim", '{0, 4, 8});

        // phase_clr coincident with the phase-2 strobe
        do_reset();
        ready_out = 1'b1;
        for (int k = 0; k < 8; k++) strobe(k * 256, k == 2);
        repeat (6) tick();
        check_q("phase_clr", '{0, 2, 6});

        // write into a full FIFO with a simultaneous pop
        do_reset();
        ready_out = 1'b0;
        for (int k = 0; k < 16; k++) strobe(k * 256, 1'b0);
        repeat (4) tick();
        strobe(16 * 256, 1'b0);
        tick();
        ready_out = 1'b1;
        tick();
        ready_out = 1'b0;
        @(negedge clk);
        chk("full+pop overflow", overflow, 0);
        tick();
        ready_out = 1'b1;
        repeat (8) tick();
        check_q("full+pop", '{0, 4, 8, 12, 16});

        // overflow: 6 kept samples into a 4-deep FIFO with no pops
        do_reset();
        ready_out = 1'b0;
        for (int k = 0; k < 16; k++) strobe(k * 256, 1'b0);
        repeat (4) tick();
        @(negedge clk);
        chk("pre-overflow flag", overflow, 0);
        chk("pre-overflow valid", valid_out, 1);
        for (int k = 16; k < 24; k++) strobe(k * 256, 1'b0);
        repeat (4) tick();
        @(negedge clk);
        chk("overflow flag", overflow, 1);
        repeat (3) tick();
        @(negedge clk);
        chk("hold dout", dout, 0);
        tick();
        ready_out = 1'b1;
        repeat (8) tick();
        ready_out = 1'b0;
        check_q("overflow drain", '{0, 4, 8, 12});
        chk("overflow sticky", overflow, 1);
        chk("overflow empty", valid_out, 0);

        // asynchronous reset with buffered samples
        do_reset();
        ready_out = 1'b0;
        for (int k = 0; k < 12; k++) strobe((k + 1) * 256, 1'b0);
        repeat (4) tick();
        chk("buffered before reset", valid_out, 1);
        rst_n = 1'b0;
        #1;
        chk("async reset valid_out", valid_out, 0);
        chk("async reset dout", dout, 0);
        chk("async reset overflow", overflow, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        ready_out = 1'b1;
        q.delete();
        repeat (6) tick();
        chk("no stale output", q.size(), 0);
        strobe(5 * 256, 1'b0);
        repeat (5) tick();
        check_q("post-reset first", '{5});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
